// File: rtl/hazard_dest_tracker.sv
// Tracks EX/MEM/WB destination registers and raises load-use stall/bubble controls.
// Latency: RD/VALID outputs are registered slot state; stall and enables are combinational from decode.
// Backpressure: HOLD freezes every slot; STALL_COUNT exists only with HAZARD_STALL_COUNT_EN.
module hazard_dest_tracker #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [REG_ADDR_W-1:0] DEC_RD,
    input  logic                  DEC_REG_WRITE,
    input  logic                  DEC_MEM_READ,
    input  logic [REG_ADDR_W-1:0] DEC_RS1,
    input  logic [REG_ADDR_W-1:0] DEC_RS2,
    input  logic                  DEC_USES_RS1,
    input  logic                  DEC_USES_RS2,
    input  logic                  HOLD,
    input  logic                  FLUSH,
    output logic [REG_ADDR_W-1:0] RD_imm_old,
    output logic [REG_ADDR_W-1:0] RD_old_old,
    output logic [REG_ADDR_W-1:0] RD_wb,
    output logic                  VALID_imm_old,
    output logic                  VALID_old_old,
    output logic                  VALID_wb,
    output logic                  LOAD_USE_STALL,
    output logic                  PC_WRITE_EN,
    output logic                  IFID_WRITE_EN,
    output logic                  IDEX_BUBBLE,
    output logic [CNT_W-1:0]      STALL_COUNT
);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  wr;
        logic                  load;
    } slot_t;

    slot_t e_q, m_q, w_q;
    slot_t dec_slot;
    logic  e_vld, m_vld, w_vld;
    logic  load_use_stall;

    assign dec_slot = '{rd: DEC_RD, wr: DEC_REG_WRITE, load: DEC_MEM_READ};

    // A write to x0 is architecturally dead, so it never counts as live.
    assign e_vld = e_q.wr & (e_q.rd != '0);
    assign m_vld = m_q.wr & (m_q.rd != '0);
    assign w_vld = w_q.wr & (w_q.rd != '0);

    assign RD_imm_old    = e_vld ? e_q.rd : '0;
    assign RD_old_old    = m_vld ? m_q.rd : '0;
    assign RD_wb         = w_vld ? w_q.rd : '0;
    assign VALID_imm_old = e_vld;
    assign VALID_old_old = m_vld;
    assign VALID_wb      = w_vld;

    assign load_use_stall = ~FLUSH & e_q.load & e_vld &
                            ((DEC_USES_RS1 & (DEC_RS1 == e_q.rd)) |
                             (DEC_USES_RS2 & (DEC_RS2 == e_q.rd)));

    assign LOAD_USE_STALL = load_use_stall;
    assign PC_WRITE_EN    = ~(HOLD | load_use_stall);
    assign IFID_WRITE_EN  = ~(HOLD | load_use_stall);
    assign IDEX_BUBBLE    = ~HOLD & (FLUSH | load_use_stall);

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            e_q <= '0;
            m_q <= '0;
            w_q <= '0;
        end else if (!HOLD) begin
            e_q <= (FLUSH | load_use_stall) ? slot_t'('0) : dec_slot;
            m_q <= e_q;
            w_q <= m_q;
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // FLUSH already masks load_use_stall, so only HOLD needs gating here.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            stall_cnt_q <= '0;
        end else if (!HOLD && load_use_stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign STALL_COUNT = stall_cnt_q;
`else
    assign STALL_COUNT = '0;
`endif

endmodule

// File: tb/tb_hazard_dest_tracker.sv
// Self-checking bench: directed scenarios plus random traffic against a slot-list reference model.
module tb_hazard_dest_tracker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic        dec_reg_write, dec_mem_read, dec_uses_rs1, dec_uses_rs2;
    logic        hold, flush;
    logic [4:0]  rd_imm_old, rd_old_old, rd_wb;
    logic        valid_imm_old, valid_old_old, valid_wb;
    logic        load_use_stall, pc_write_en, ifid_write_en, idex_bubble;
    logic [31:0] stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: index 0 = EX, 1 = MEM, 2 = WB
    int          m_rd[3];
    bit          m_wr[3];
    bit          m_ld[3];
    int unsigned m_cnt;

    always #5 clk = ~clk;

    hazard_dest_tracker #(.REG_ADDR_W(5), .CNT_W(32)) dut (
        .CLK(clk), .RESET_N(reset_n),
        .DEC_RD(dec_rd), .DEC_REG_WRITE(dec_reg_write), .DEC_MEM_READ(dec_mem_read),
        .DEC_RS1(dec_rs1), .DEC_RS2(dec_rs2),
        .DEC_USES_RS1(dec_uses_rs1), .DEC_USES_RS2(dec_uses_rs2),
        .HOLD(hold), .FLUSH(flush),
        .RD_imm_old(rd_imm_old), .RD_old_old(rd_old_old), .RD_wb(rd_wb),
        .VALID_imm_old(valid_imm_old), .VALID_old_old(valid_old_old), .VALID_wb(valid_wb),
        .LOAD_USE_STALL(load_use_stall), .PC_WRITE_EN(pc_write_en),
        .IFID_WRITE_EN(ifid_write_en), .IDEX_BUBBLE(idex_bubble),
        .STALL_COUNT(stall_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit live(input int i);
        return m_wr[i] && (m_rd[i] != 0);
    endfunction

    function automatic int exp_rd(input int i);
        return live(i) ? m_rd[i] : 0;
    endfunction

    function automatic bit model_hazard();
        if (flush || !live(0) || !m_ld[0]) return 1'b0;
        return (dec_uses_rs1 && (int'(dec_rs1) == m_rd[0])) ||
               (dec_uses_rs2 && (int'(dec_rs2) == m_rd[0]));
    endfunction

    function automatic int exp_cnt();
`ifdef HAZARD_STALL_COUNT_EN
        return int'(m_cnt);
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_rd[i] = 0; m_wr[i] = 0; m_ld[i] = 0;
        end
        m_cnt = 0;
    endtask

    // One pipeline cycle: drive at negedge, check just after, advance model at posedge.
    task automatic cycle(input bit rst, input logic [4:0] rd, input bit wr, input bit ld,
                         input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2,
                         input bit hld, input bit fl, input bit chk);
        bit haz;
        @(negedge clk);
        reset_n = ~rst; dec_rd = rd; dec_reg_write = wr; dec_mem_read = ld;
        dec_rs1 = rs1; dec_uses_rs1 = u1; dec_rs2 = rs2; dec_uses_rs2 = u2;
        hold = hld; flush = fl;
        #1;
        haz = model_hazard();
        if (chk) begin
            check("rd_e",   32'(rd_imm_old),    32'(exp_rd(0)));
            check("rd_m",   32'(rd_old_old),    32'(exp_rd(1)));
            check("rd_w",   32'(rd_wb),         32'(exp_rd(2)));
            check("vld_e",  32'(valid_imm_old), 32'(live(0)));
            check("vld_m",  32'(valid_old_old), 32'(live(1)));
            check("vld_w",  32'(valid_wb),      32'(live(2)));
            check("stall",  32'(load_use_stall), 32'(haz));
            check("pc_we",  32'(pc_write_en),   32'(!(hld || haz)));
            check("ifid_we", 32'(ifid_write_en), 32'(!(hld || haz)));
            check("bubble", 32'(idex_bubble),   32'(!hld && (fl || haz)));
            check("count",  stall_count,        32'(exp_cnt()));
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!hld) begin
            for (int i = 2; i > 0; i--) begin
                m_rd[i] = m_rd[i-1]; m_wr[i] = m_wr[i-1]; m_ld[i] = m_ld[i-1];
            end
            if (fl || haz) begin
                m_rd[0] = 0; m_wr[0] = 0; m_ld[0] = 0;
            end else begin
                m_rd[0] = int'(rd); m_wr[0] = wr; m_ld[0] = ld;
            end
            if (haz && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end
    endtask

    task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        cycle(0, rd, 1, 0, rs1, 1, rs2, 1, 0, 0, 1);
    endtask

    task automatic lw(input logic [4:0] rd, input logic [4:0] rs1);
        cycle(0, rd, 1, 1, rs1, 1, 5'd0, 0, 0, 0, 1);
    endtask

    task automatic nop();
        cycle(0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 1);
    endtask

    initial begin
        int unsigned base_cnt;
        model_reset();
        // Reset with random decode inputs; the first cycle precedes any reset edge.
        cycle(1, 5'($urandom), 1, 1, 5'($urandom), 1, 5'($urandom), 1, 0, 0, 0);
        cycle(1, 5'($urandom), 1, 1, 5'($urandom), 1, 5'($urandom), 1, 0, 0, 1);
        nop();

        // Normal flow
        alu(5'd5, 5'd1, 5'd2);
        alu(5'd6, 5'd1, 5'd2);
        alu(5'd7, 5'd1, 5'd2);
        #1;
        check("flow_e", 32'(rd_imm_old), 32'd7);
        check("flow_m", 32'(rd_old_old), 32'd6);
        check("flow_w", 32'(rd_wb), 32'd5);
        check("flow_vld", 32'({valid_imm_old, valid_old_old, valid_wb}), 32'h7);

        // Load-use: consumer presented twice because IF/ID holds it
        base_cnt = m_cnt;
        lw(5'd8, 5'd2);
        alu(5'd9, 5'd8, 5'd1);
        alu(5'd9, 5'd8, 5'd1);
        check("lu_cnt", m_cnt - base_cnt, 32'd1);

        // x0 load and non-user of RS2
        lw(5'd0, 5'd1);
        alu(5'd9, 5'd0, 5'd0);
        lw(5'd4, 5'd1);
        cycle(0, 5'd10, 1, 0, 5'd1, 1, 5'd4, 0, 0, 0, 1);

        // HOLD during hazard
        base_cnt = m_cnt;
        lw(5'd3, 5'd1);
        for (int i = 0; i < 3; i++) cycle(0, 5'd12, 1, 0, 5'd3, 1, 5'd0, 0, 1, 0, 1);
        alu(5'd12, 5'd3, 5'd0);
        alu(5'd12, 5'd3, 5'd0);
        check("hold_cnt", m_cnt - base_cnt, 32'd1);

        // FLUSH during hazard, then reset during a stall
        base_cnt = m_cnt;
        lw(5'd10, 5'd1);
        cycle(0, 5'd13, 1, 0, 5'd10, 1, 5'd0, 0, 0, 1, 1);
        check("flush_cnt", m_cnt - base_cnt, 32'd0);
        lw(5'd11, 5'd1);
        cycle(1, 5'd14, 1, 0, 5'd11, 1, 5'd0, 0, 0, 0, 1);
        nop();

        // Random traffic with a small register range to provoke hazards
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 49) == 0),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_dest_tracker.md
Name: hazard_dest_tracker

Overview:
- Producer side of the pipeline forwarding path. Tracks the destination register of every in-flight instruction across the EX, MEM and WB slots.
- Supplies the forwarding selector with RD_imm_old (instruction one ahead of decode) and RD_old_old (two ahead).
- Detects load-use hazards and generates stall and bubble controls for PC, IF/ID and ID/EX.
- Sits beside the decode stage; its slot state advances in lockstep with the pipeline registers.

Parameters:
- REG_ADDR_W, 5, register address width
- CNT_W, 32, width of the optional stall counter

Ports:
- CLK  input  1  pipeline clock, rising edge
- RESET_N  input  1  synchronous active-low reset
- DEC_RD  input  REG_ADDR_W  destination of instruction in decode
- DEC_REG_WRITE  input  1  decode instruction writes the register file
- DEC_MEM_READ  input  1  decode instruction is a load
- DEC_RS1  input  REG_ADDR_W  source 1 of decode instruction
- DEC_RS2  input  REG_ADDR_W  source 2 of decode instruction
- DEC_USES_RS1  input  1  RS1 is a real operand
- DEC_USES_RS2  input  1  RS2 is a real operand
- HOLD  input  1  global freeze (memory wait); no slot advances
- FLUSH  input  1  branch/jump taken; decode instruction is discarded
- RD_imm_old  output  REG_ADDR_W  EX-slot destination, 0 if slot not writing
- RD_old_old  output  REG_ADDR_W  MEM-slot destination, 0 if slot not writing
- RD_wb  output  REG_ADDR_W  WB-slot destination, 0 if slot not writing
- VALID_imm_old, VALID_old_old, VALID_wb  output  1 each  corresponding slot holds a live write to a register other than x0
- LOAD_USE_STALL  output  1  combinational load-use hazard
- PC_WRITE_EN  output  1  PC may update
- IFID_WRITE_EN  output  1  IF/ID may update
- IDEX_BUBBLE  output  1  ID/EX must load a NOP
- STALL_COUNT  output  CNT_W  load-use stall cycles (see optional feature)

Behaviour:
- Each slot (E, M, W) holds {rd, wr, load}. A slot is valid only when wr=1 and rd≠0; an invalid slot drives RD=0 and VALID=0. An x0 destination is stored as invalid.
- Reset: checked on the CLK edge when RESET_N=0. Clears all slots. All RD outputs are 0 and all VALID outputs are 0 from the following cycle. Reset has priority over everything and aborts any stall in progress.
- RD_* and VALID_* outputs are registered and taken directly from slot state; there is no combinational path from DEC_* inputs to them.
- LOAD_USE_STALL = E.load & E valid & ((DEC_USES_RS1 & DEC_RS1==E.rd) | (DEC_USES_RS2 & DEC_RS2==E.rd)). It is forced to 0 while FLUSH=1.
- Slot update priority per edge:
  1. RESET_N low: all slots cleared.
  2. HOLD: all slots keep their values.
  3. FLUSH: E<=bubble, M<=E, W<=M.
  4. LOAD_USE_STALL: E<=bubble, M<=E, W<=M.
  5. Otherwise: E<={DEC_RD, DEC_REG_WRITE, DEC_MEM_READ}, M<=E, W<=M.
- A bubble is {0, 0, 0}.
- PC_WRITE_EN = IFID_WRITE_EN = ~(HOLD | LOAD_USE_STALL).
- IDEX_BUBBLE = ~HOLD & (FLUSH | LOAD_USE_STALL).
- Load-use latency: exactly one bubble cycle. The cycle after the stall, the load sits in M, RD_old_old equals the load's rd, and LOAD_USE_STALL deasserts.
- HOLD concurrent with a hazard: LOAD_USE_STALL stays asserted, nothing shifts, and the single bubble is inserted on the first non-HOLD edge.
- FLUSH concurrent with a hazard: FLUSH wins and no stall is counted.
- Back-to-back loads with dependent consumers each produce one bubble.

Optional Feature:
- Macro: HAZARD_STALL_COUNT_EN.
- Defined: STALL_COUNT increments on every edge where RESET_N=1, HOLD=0, FLUSH=0 and LOAD_USE_STALL=1. It saturates at all-ones and resets to 0.
- Undefined: STALL_COUNT is tied to 0 and no counter register is built.

Test Plan:
- Reset: RESET_N=0 for 2 cycles with random DEC_* inputs -> all RD_*=0, all VALID_*=0, PC_WRITE_EN=1, STALL_COUNT=0.
- Normal flow: add x5, then add x6, then add x7 -> after the 3rd edge RD_imm_old=7, RD_old_old=6, RD_wb=5, all valid, no stall.
- Load-use: lw x8, then add x9,x8,x1 -> LOAD_USE_STALL=1, PC_WRITE_EN=0, IDEX_BUBBLE=1 for exactly 1 cycle. Next cycle RD_imm_old=0, RD_old_old=8, STALL_COUNT=1 (macro on).
- x0 and non-users: lw x0 followed by a reader of x0 -> no stall, VALID_imm_old=0. lw x4 followed by an instruction with DEC_USES_RS2=0 and RS2=4 -> no stall.
- HOLD during hazard: lw x3, then use x3 with HOLD=1 for 3 cycles -> slots frozen, stall held, exactly 1 bubble after HOLD drops, STALL_COUNT=1.
- FLUSH plus reset mid-stall: FLUSH=1 during a hazard -> bubble inserted, LOAD_USE_STALL=0, STALL_COUNT unchanged. RESET_N=0 during a stall -> all slots clear on that edge.
